// File: rtl/reg_xfer_pkg.sv
// ---------------------------------------------------------------------------
// reg_xfer_pkg
// Shared types for the register-transfer sequencer: FSM state encoding,
// bus-select encodings, the packed transfer request, and an index range
// helper. Indices are carried at MAX_IDX_W bits so the request type does not
// depend on the instantiating module's IDX_W (which must be <= MAX_IDX_W).
// ---------------------------------------------------------------------------
package reg_xfer_pkg;

  localparam int unsigned MAX_IDX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam logic BUS_IN  = 1'b0;  // Store / Load strobes
  localparam logic BUS_IN2 = 1'b1;  // Store2 / Load2 strobes

  typedef struct packed {
    logic                 bus;
    logic [MAX_IDX_W-1:0] src;
    logic [MAX_IDX_W-1:0] dst;
  } xfer_req_t;

  // True when idx addresses one of the num_regs attached registers.
  function automatic logic idx_in_range(input logic [MAX_IDX_W-1:0] idx,
                                        input int unsigned num_regs);
    return ({16'd0, idx} < num_regs);
  endfunction

endpackage

// File: rtl/reg_xfer_sequencer_onehot_dec.sv
// ---------------------------------------------------------------------------
// reg_xfer_onehot_dec
// Index to one-hot decoder with enable. An index outside 0..NUM_REGS-1
// produces all zeros, so unattached indices never strobe anything.
// Ports:
//   en     - decoder enable; 0 forces all-zero output
//   idx    - register index
//   onehot - one-hot select, bit i set when en && idx == i
// ---------------------------------------------------------------------------
module reg_xfer_onehot_dec #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = 16
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  // Compare the index against every attached register position.
  always_comb begin
    onehot = {NUM_REGS{1'b0}};
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (en && (idx == IDX_W'(i))) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// reg_xfer_sequencer
// Sequences register-to-register transfers on a dual tristate bus: one DRIVE
// cycle (source Store strobe only, bus settles) then one LATCH cycle (Store
// held, destination Load strobe). A one-entry pending slot lets a new request
// be accepted during DRIVE so transfers run back to back, one per 2 cycles.
// All strobes are registered and derived from the next state, so at most one
// register drives each bus in any cycle.
// Optional build macro REG_XFER_CHECK_EN: adds output err and rejects
// requests with src==dst or an out-of-range index (no strobes, err pulse in
// place of done, not counted).
// Ports:
//   Clk, Reset          - clock, asynchronous active-low reset
//   req_valid/req_ready - request handshake (ready = pending slot empty)
//   req_src/req_dst     - source / destination register index
//   req_bus             - 0: IN bus (Store/Load), 1: IN2 bus (Store2/Load2)
//   Store/Store2        - one-hot drive enables
//   Load/Load2          - one-hot capture enables
//   busy                - engine in DRIVE or LATCH
//   done                - one-cycle pulse per completed transfer
//   err                 - (macro only) one-cycle pulse per rejected transfer
//   xfer_count          - completed transfers, wraps silently
// ---------------------------------------------------------------------------
module reg_xfer_sequencer
  import reg_xfer_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [IDX_W-1:0]    req_dst,
  input  logic                req_bus,
  output logic [NUM_REGS-1:0] Store,
  output logic [NUM_REGS-1:0] Store2,
  output logic [NUM_REGS-1:0] Load,
  output logic [NUM_REGS-1:0] Load2,
  output logic                busy,
  output logic                done,
`ifdef REG_XFER_CHECK_EN
  output logic                err,
`endif
  output logic [CNT_W-1:0]    xfer_count
);

  state_e                state_q, state_d;
  xfer_req_t             cur_q, cur_d;
  xfer_req_t             pend_q, pend_d;
  xfer_req_t             req_s;
  logic                  pend_vld_q, pend_vld_d;
  logic                  rej_q, rej_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REGS-1:0]   store_q, store_d, store2_q, store2_d;
  logic [NUM_REGS-1:0]   load_q, load_d, load2_q, load2_d;
  logic [NUM_REGS-1:0]   src_oh_s, dst_oh_s;
  logic                  accept_s, drive_en_s, latch_en_s;
`ifdef REG_XFER_CHECK_EN
  logic                  err_q, err_d;

  function automatic logic is_bad(input xfer_req_t r);
    return (r.src == r.dst) || !idx_in_range(r.src, NUM_REGS)
           || !idx_in_range(r.dst, NUM_REGS);
  endfunction
`endif

  assign accept_s = req_valid && ready_q;
  assign req_s    = '{bus: req_bus, src: MAX_IDX_W'(req_src), dst: MAX_IDX_W'(req_dst)};

  // Next-state and request routing: pending slot has priority over a new request.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    case (state_q)
      IDLE, LATCH: begin
        if (pend_vld_q) begin
          state_d    = DRIVE;
          cur_d      = pend_q;
          pend_vld_d = 1'b0;
        end else if (accept_s) begin
          state_d = DRIVE;
          cur_d   = req_s;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        state_d = LATCH;
        if (accept_s) begin
          pend_d     = req_s;
          pend_vld_d = 1'b1;
        end else begin
          pend_vld_d = pend_vld_q;
        end
      end
      default: begin
        state_d    = IDLE;
        pend_vld_d = 1'b0;
      end
    endcase
`ifdef REG_XFER_CHECK_EN
    rej_d = is_bad(cur_d);
`else
    rej_d = 1'b0;
`endif
  end

  // Strobe enables come from the next state so the outputs can be registered.
  assign drive_en_s = (state_d != IDLE) && !rej_d;
  assign latch_en_s = (state_d == LATCH) && !rej_d;

  reg_xfer_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(MAX_IDX_W)) u_src_dec (
    .en     (drive_en_s),
    .idx    (cur_d.src),
    .onehot (src_oh_s)
  );

  reg_xfer_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(MAX_IDX_W)) u_dst_dec (
    .en     (latch_en_s),
    .idx    (cur_d.dst),
    .onehot (dst_oh_s)
  );

  // Route decoded strobes to the selected bus and derive status outputs.
  always_comb begin
    store_d  = {NUM_REGS{1'b0}};
    store2_d = {NUM_REGS{1'b0}};
    load_d   = {NUM_REGS{1'b0}};
    load2_d  = {NUM_REGS{1'b0}};
    if (cur_d.bus == BUS_IN2) begin
      store2_d = src_oh_s;
      load2_d  = dst_oh_s;
    end else begin
      store_d = src_oh_s;
      load_d  = dst_oh_s;
    end
    ready_d = !pend_vld_d;
    busy_d  = (state_d != IDLE);
    // done lands in the cycle after LATCH, together with the count update.
    done_d  = (state_q == LATCH) && !rej_q;
`ifdef REG_XFER_CHECK_EN
    err_d   = (state_q == LATCH) && rej_q;
`endif
    if (done_d) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and registered outputs; reset clears everything including in-flight work.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cur_q      <= {$bits(xfer_req_t){1'b0}};
      pend_q     <= {$bits(xfer_req_t){1'b0}};
      pend_vld_q <= 1'b0;
      rej_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      store_q    <= {NUM_REGS{1'b0}};
      store2_q   <= {NUM_REGS{1'b0}};
      load_q     <= {NUM_REGS{1'b0}};
      load2_q    <= {NUM_REGS{1'b0}};
`ifdef REG_XFER_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      rej_q      <= rej_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      store_q    <= store_d;
      store2_q   <= store2_d;
      load_q     <= load_d;
      load2_q    <= load2_d;
`ifdef REG_XFER_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign req_ready  = ready_q;
  assign Store      = store_q;
  assign Store2     = store2_q;
  assign Load       = load_q;
  assign Load2      = load2_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign xfer_count = cnt_q;
`ifdef REG_XFER_CHECK_EN
  assign err        = err_q;
`endif

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_xfer_sequencer
// Self-checking bench for reg_xfer_sequencer (NUM_REGS=8, IDX_W=3, CNT_W=4).
// Builds with or without REG_XFER_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_reg_xfer_sequencer;

`ifdef REG_XFER_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] st2;
    logic [7:0] ld;
    logic [7:0] ld2;
    logic       err;
  } exp_t;

  typedef struct {
    logic [2:0] src;
    logic [2:0] dst;
    logic       bus;
    exp_t       exp;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_src = 3'd0;
  logic [2:0] req_dst = 3'd0;
  logic       req_bus = 1'b0;
  logic [7:0] Store, Store2, Load, Load2;
  logic       busy, done, err_w;
  logic [3:0] xfer_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  logic [3:0] exp_count = 4'd0;
  logic saw_not_ready = 1'b0;
  exp_t sb_q[$];
  int   done_cyc[$];
  vec_t tbl[8];

  reg_xfer_sequencer #(.NUM_REGS(8), .IDX_W(3), .CNT_W(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .req_bus    (req_bus),
    .Store      (Store),
    .Store2     (Store2),
    .Load       (Load),
    .Load2      (Load2),
    .busy       (busy),
    .done       (done),
`ifdef REG_XFER_CHECK_EN
    .err        (err_w),
`endif
    .xfer_count (xfer_count)
  );
`ifndef REG_XFER_CHECK_EN
  assign err_w = 1'b0;
`endif

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t exp_model(input logic [2:0] s, input logic [2:0] d, input logic b);
    exp_t e;
    logic [7:0] os, od;
    os = 8'h01 << s;
    od = 8'h01 << d;
    e.err = CHK_EN && (s == d);
    if (e.err) begin
      os = 8'h00;
      od = 8'h00;
    end
    e.st  = b ? 8'h00 : os;
    e.st2 = b ? os : 8'h00;
    e.ld  = b ? 8'h00 : od;
    e.ld2 = b ? od : 8'h00;
    return e;
  endfunction

  // Called at a negedge; leaves req_valid high and returns at the negedge after acceptance.
  task automatic send(input logic [2:0] s, input logic [2:0] d, input logic b, input exp_t e);
    int budget = 20;
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    req_bus   = b;
    while (req_ready !== 1'b1 && budget > 0) begin
      saw_not_ready = 1'b1;
      @(negedge Clk);
      budget--;
    end
    if (budget == 0) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      sb_q.push_back(e);
      @(negedge Clk);
    end
  endtask

  task automatic drain();
    int budget = 40;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    @(negedge Clk);
  endtask

  // Monitor: bus exclusivity every cycle; on done/err pop the scoreboard and
  // check the DRIVE (two cycles back) and LATCH (one cycle back) strobes.
  initial begin
    logic [7:0] p1_st, p1_st2, p1_ld, p1_ld2, p2_st, p2_st2, p2_ld, p2_ld2;
    exp_t e;
    {p1_st, p1_st2, p1_ld, p1_ld2, p2_st, p2_st2, p2_ld, p2_ld2} = 64'd0;
    forever begin
      @(negedge Clk);
      chk("bus_excl", 32'(($countones(Store) > 1) || ($countones(Store2) > 1) ||
                          ((Store != 8'h00) && (Store2 != 8'h00)) ||
                          ($countones(Load) > 1) || ($countones(Load2) > 1)), 32'd0);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 || err_w === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("drive_store",  32'({p2_st, p2_st2}), 32'({e.st, e.st2}));
          chk("drive_noload", 32'({p2_ld, p2_ld2}), 32'd0);
          chk("latch_store",  32'({p1_st, p1_st2}), 32'({e.st, e.st2}));
          chk("latch_load",   32'({p1_ld, p1_ld2}), 32'({e.ld, e.ld2}));
          chk("done_err",     32'({done, err_w}), 32'({~e.err, e.err}));
          if (!e.err) exp_count = exp_count + 4'd1;
          chk("xfer_count",   32'(xfer_count), 32'(exp_count));
          done_cyc.push_back(cyc);
        end
      end
      {p2_st, p2_st2, p2_ld, p2_ld2} = {p1_st, p1_st2, p1_ld, p1_ld2};
      {p1_st, p1_st2, p1_ld, p1_ld2} = {Store, Store2, Load, Load2};
    end
  end

  initial begin
    int   c0, bc0;
    logic [3:0] snap;
    logic [7:0] e44;
    logic [31:0] any_en;
    logic [31:0] any_busy;

    tbl[0] = '{3'd0, 3'd1, 1'b0, '{8'h01, 8'h00, 8'h02, 8'h00, 1'b0}};
    tbl[1] = '{3'd7, 3'd6, 1'b1, '{8'h00, 8'h80, 8'h00, 8'h40, 1'b0}};
    tbl[2] = '{3'd5, 3'd2, 1'b1, '{8'h00, 8'h20, 8'h00, 8'h04, 1'b0}};
    tbl[3] = '{3'd3, 3'd0, 1'b0, '{8'h08, 8'h00, 8'h01, 8'h00, 1'b0}};
    tbl[5] = '{3'd6, 3'd3, 1'b1, '{8'h00, 8'h40, 8'h00, 8'h08, 1'b0}};
    tbl[6] = '{3'd2, 3'd7, 1'b0, '{8'h04, 8'h00, 8'h80, 8'h00, 1'b0}};
`ifdef REG_XFER_CHECK_EN
    tbl[4] = '{3'd4, 3'd4, 1'b0, '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1}};
    tbl[7] = '{3'd1, 3'd1, 1'b1, '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1}};
`else
    tbl[4] = '{3'd4, 3'd4, 1'b0, '{8'h10, 8'h00, 8'h10, 8'h00, 1'b0}};
    tbl[7] = '{3'd1, 3'd1, 1'b1, '{8'h00, 8'h02, 8'h00, 8'h02, 1'b0}};
`endif

    // Reset with a request presented.
    Reset = 1'b0;
    req_valid = 1'b1; req_src = 3'd2; req_dst = 3'd5; req_bus = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_enables", 32'({Store, Store2, Load, Load2}), 32'd0);
    chk("rst_ready",   32'(req_ready), 32'd0);
    chk("rst_count",   32'(xfer_count), 32'd0);
    chk("rst_status",  32'({busy, done, err_w}), 32'd0);
    Reset = 1'b1;
    req_valid = 1'b0;
    @(negedge Clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Single transfer 2 -> 5 on IN, explicit cycle timing.
    snap = exp_count;
    send(3'd2, 3'd5, 1'b0, exp_model(3'd2, 3'd5, 1'b0));
    req_valid = 1'b0;
    chk("single_c1", 32'({Store, Store2, Load, Load2}), {8'h04, 8'h00, 8'h00, 8'h00});
    @(negedge Clk);
    chk("single_c2", 32'({Store, Store2, Load, Load2}), {8'h04, 8'h00, 8'h20, 8'h00});
    @(negedge Clk);
    chk("single_c3_done", 32'(done), 32'd1);
    chk("single_c3_cnt",  32'(xfer_count), 32'(snap + 4'd1));
    chk("single_c3_idle", 32'({Store, Store2, Load, Load2}), 32'd0);
    drain();

    // Three back-to-back transfers on IN2 with req_valid held.
    done_cyc.delete();
    saw_not_ready = 1'b0;
    bc0 = busy_cnt;
    send(3'd1, 3'd3, 1'b1, exp_model(3'd1, 3'd3, 1'b1));
    c0 = cyc;
    send(3'd3, 3'd7, 1'b1, exp_model(3'd3, 3'd7, 1'b1));
    send(3'd7, 3'd0, 1'b1, exp_model(3'd7, 3'd0, 1'b1));
    req_valid = 1'b0;
    drain();
    chk("b2b_ready_drop", 32'(saw_not_ready), 32'd1);
    chk("b2b_ndone", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      chk("b2b_done1", 32'(done_cyc[0]), 32'(c0 + 2));
      chk("b2b_done2", 32'(done_cyc[1]), 32'(c0 + 4));
      chk("b2b_done3", 32'(done_cyc[2]), 32'(c0 + 6));
    end
    chk("b2b_busy_cycles", 32'(busy_cnt - bc0), 32'd6);
    chk("b2b_count", 32'(xfer_count), 32'd4);

    // Table-driven vectors, issued back to back.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].src, tbl[i].dst, tbl[i].bus, tbl[i].exp);
    end
    req_valid = 1'b0;
    drain();

    // src == dst = 4: reload (or reject when checking is built in).
    e44 = CHK_EN ? 8'h00 : 8'h10;
    snap = exp_count;
    send(3'd4, 3'd4, 1'b0, exp_model(3'd4, 3'd4, 1'b0));
    req_valid = 1'b0;
    chk("same_c1_store", 32'({Store, Load}), 32'({e44, 8'h00}));
    @(negedge Clk);
    chk("same_c2_load", 32'({Store, Load}), 32'({e44, e44}));
    @(negedge Clk);
    chk("same_c3_done_err", 32'({done, err_w}), 32'({~CHK_EN, CHK_EN}));
    chk("same_c3_cnt", 32'(xfer_count), 32'(snap + (CHK_EN ? 4'd0 : 4'd1)));
    drain();

    // Reset during LATCH with a pending request.
    send(3'd2, 3'd6, 1'b0, exp_model(3'd2, 3'd6, 1'b0));
    send(3'd4, 3'd1, 1'b0, exp_model(3'd4, 3'd1, 1'b0));
    chk("pre_rst_latch", 32'(Load), 32'h40);
    Reset = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_mid_enables", 32'({Store, Store2, Load, Load2}), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    sb_q.delete();
    exp_count = 4'd0;
    @(negedge Clk);
    Reset = 1'b1;
    any_en = 32'd0;
    any_busy = 32'd0;
    repeat (6) begin
      @(negedge Clk);
      any_en = any_en | 32'({Store, Store2, Load, Load2});
      any_busy = any_busy | 32'(busy);
    end
    chk("post_rst_no_stale", any_en, 32'd0);
    chk("post_rst_busy", any_busy, 32'd0);
    chk("post_rst_count", 32'(xfer_count), 32'd0);

    // Counter wrap with CNT_W = 4.
    for (int i = 0; i < 15; i++) begin
      send(3'(i % 8), 3'((i + 3) % 8), 1'(i % 2),
           exp_model(3'(i % 8), 3'((i + 3) % 8), 1'(i % 2)));
    end
    req_valid = 1'b0;
    drain();
    chk("wrap_15", 32'(xfer_count), 32'd15);
    send(3'd0, 3'd1, 1'b0, exp_model(3'd0, 3'd1, 1'b0));
    req_valid = 1'b0;
    drain();
    chk("wrap_16", 32'(xfer_count), 32'd0);
    send(3'd6, 3'd2, 1'b1, exp_model(3'd6, 3'd2, 1'b1));
    req_valid = 1'b0;
    drain();
    chk("wrap_17", 32'(xfer_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
